// File: rtl/multi_one_shot_pkg.sv
// Shared encodings for the multi-channel one-shot: channel FSM states,
// trigger mode codes and the per-channel status bundle.
package multi_one_shot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } ch_state_t;

  localparam logic [1:0] MODE_NORETRIG = 2'b00;
  localparam logic [1:0] MODE_RETRIG   = 2'b01;
  localparam logic [1:0] MODE_HOLDOFF  = 2'b10;

  typedef struct packed {
    logic out;
    logic busy;
    logic done;
    logic miss;
  } ch_status_t;

endpackage

// File: rtl/one_shot_ch.sv
// Single monostable channel: trigger edge detect, IDLE/PULSE/HOLD FSM,
// shared duration/holdoff down-counter and sticky miss flag.
module one_shot_ch
  import multi_one_shot_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] dur,
  input  logic [CNT_W-1:0] holdoff,
  input  logic [1:0]       mode,
  input  logic             clr_miss,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             miss
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_t        st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             prev_trig;
  ch_status_t       stat, stat_n;
  logic             trig_edge;
  logic             retrig;
  logic             done_n;
  logic             miss_set;

  assign trig_edge = trig_in & ~prev_trig;
  // Mode 11 falls through to non-retriggerable behaviour.
  assign retrig    = (mode == MODE_RETRIG);

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    done_n   = 1'b0;
    miss_set = 1'b0;
    if (!en) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (trig_edge && dur != '0) begin
            st_n  = ST_PULSE;
            cnt_n = dur - ONE;
          end
        end
        ST_PULSE: begin
          if (trig_edge && retrig && dur != '0) begin
            cnt_n = dur - ONE;
          end else begin
            // Retrigger with dur=0 is silently dropped; other modes record a miss.
            if (trig_edge && !retrig) miss_set = 1'b1;
            if (cnt != '0) begin
              cnt_n = cnt - ONE;
            end else begin
              done_n = 1'b1;
              if (mode == MODE_HOLDOFF && holdoff != '0) begin
                st_n  = ST_HOLD;
                cnt_n = holdoff - ONE;
              end else begin
                st_n  = ST_IDLE;
              end
            end
          end
        end
        ST_HOLD: begin
          miss_set = trig_edge;
          if (cnt != '0) cnt_n = cnt - ONE;
          else           st_n  = ST_IDLE;
        end
        default: begin
          st_n  = ST_IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    stat_n.out  = (st_n == ST_PULSE);
    stat_n.busy = (st_n != ST_IDLE);
    stat_n.done = done_n;
    // Set wins over a simultaneous clear.
    stat_n.miss = (stat.miss & ~clr_miss) | miss_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      prev_trig <= 1'b1;
      stat      <= '0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      prev_trig <= trig_in;
      stat      <= stat_n;
    end
  end

  assign out  = stat.out;
  assign busy = stat.busy;
  assign done = stat.done;
  assign miss = stat.miss;

endmodule

// File: rtl/multi_one_shot.sv
// N-channel programmable one-shot: one independent channel per trigger,
// each taking its own slice of the packed duration bus.
module multi_one_shot
  import multi_one_shot_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       trig_in,
  input  logic [N_CH*CNT_W-1:0] dur,
  input  logic [CNT_W-1:0]      holdoff,
  input  logic [1:0]            mode,
  input  logic                  clr_miss,
  output logic [N_CH-1:0]       out,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       miss
);

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      one_shot_ch #(.CNT_W(CNT_W)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .en       (en[i]),
        .trig_in  (trig_in[i]),
        .dur      (dur[i*CNT_W +: CNT_W]),
        .holdoff  (holdoff),
        .mode     (mode),
        .clr_miss (clr_miss),
        .out      (out[i]),
        .busy     (busy[i]),
        .done     (done[i]),
        .miss     (miss[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_one_shot.sv
// Directed bench for multi_one_shot: expectations are queued with their
// target cycle and checked on the falling edge when that cycle arrives.
module tb_multi_one_shot;

  localparam int N = 4;
  localparam int W = 8;
  localparam int F_OUT = 0, F_BUSY = 1, F_DONE = 2, F_MISS = 3;

  logic           clk, rst, clr_miss;
  logic [N-1:0]   en, trig_in, out, busy, done, miss;
  logic [N*W-1:0] dur;
  logic [W-1:0]   holdoff;
  logic [1:0]     mode;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int b;

  typedef struct {
    int         cyc;
    string      tag;
    int         f;
    logic [3:0] m;
    logic [3:0] v;
  } exp_t;
  exp_t sb[$];

  multi_one_shot #(.N_CH(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .trig_in(trig_in), .dur(dur),
    .holdoff(holdoff), .mode(mode), .clr_miss(clr_miss),
    .out(out), .busy(busy), .done(done), .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] fld(input int f);
    case (f)
      F_OUT:   fld = out;
      F_BUSY:  fld = busy;
      F_DONE:  fld = done;
      default: fld = miss;
    endcase
  endfunction

  task automatic exp_rng(input string tag, input int f, input logic [3:0] m,
                         input logic [3:0] v, input int from, input int to);
    exp_t e;
    for (int c = from; c <= to; c++) begin
      e.cyc = c; e.tag = tag; e.f = f; e.m = m; e.v = v;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk($sformatf("%s@%0d", sb[i].tag, cyc), fld(sb[i].f) & sb[i].m, sb[i].v);
        sb.delete(i);
      end
    end
  end

  task automatic step_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic set_dur(input int ch, input logic [W-1:0] v);
    dur[ch*W +: W] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = '1; trig_in = 4'b0001; dur = '0; holdoff = '0;
    mode = 2'b00; clr_miss = 1'b0;
    #3;
    chk("rst_out", out, 4'h0);
    chk("rst_busy", busy, 4'h0);
    chk("rst_done", done, 4'h0);
    chk("rst_miss", miss, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Trigger held high through reset release is not an edge.
    b = cyc;
    exp_rng("thru_rst_out", F_OUT, 4'hF, 4'h0, b + 1, b + 4);
    exp_rng("thru_rst_busy", F_BUSY, 4'hF, 4'h0, b + 1, b + 4);
    step_to(b + 5);
    trig_in = '0;
    step_to(b + 7);

    // Basic non-retriggerable pulse, dur=3.
    b = cyc; set_dur(0, 8'd3); mode = 2'b00;
    exp_rng("basic_out_hi", F_OUT, 4'h1, 4'h1, b + 10, b + 12);
    exp_rng("basic_out_lo", F_OUT, 4'h1, 4'h0, b + 13, b + 14);
    exp_rng("basic_done0", F_DONE, 4'h1, 4'h0, b + 10, b + 12);
    exp_rng("basic_done1", F_DONE, 4'h1, 4'h1, b + 13, b + 13);
    exp_rng("basic_done0b", F_DONE, 4'h1, 4'h0, b + 14, b + 14);
    exp_rng("basic_miss", F_MISS, 4'hF, 4'h0, b + 13, b + 13);
    step_to(b + 9);  trig_in[0] = 1'b1;
    step_to(b + 12); trig_in[0] = 1'b0;
    step_to(b + 16);

    // Non-retriggerable miss and clear.
    b = cyc; set_dur(0, 8'd5);
    exp_rng("nr_out_hi", F_OUT, 4'h1, 4'h1, b + 10, b + 14);
    exp_rng("nr_out_lo", F_OUT, 4'h1, 4'h0, b + 15, b + 15);
    exp_rng("nr_done", F_DONE, 4'h1, 4'h1, b + 15, b + 15);
    exp_rng("nr_miss0", F_MISS, 4'h1, 4'h0, b + 11, b + 11);
    exp_rng("nr_miss1", F_MISS, 4'h1, 4'h1, b + 12, b + 19);
    exp_rng("nr_clr", F_MISS, 4'h1, 4'h0, b + 20, b + 21);
    step_to(b + 9);  trig_in[0] = 1'b1;
    step_to(b + 10); trig_in[0] = 1'b0;
    step_to(b + 11); trig_in[0] = 1'b1;
    step_to(b + 12); trig_in[0] = 1'b0;
    step_to(b + 19); clr_miss = 1'b1;
    step_to(b + 20); clr_miss = 1'b0;
    step_to(b + 22);

    // Retrigger mid-pulse, dur=4.
    b = cyc; set_dur(0, 8'd4); mode = 2'b01;
    exp_rng("rt_out_hi", F_OUT, 4'h1, 4'h1, b + 10, b + 15);
    exp_rng("rt_out_lo", F_OUT, 4'h1, 4'h0, b + 16, b + 16);
    exp_rng("rt_done0", F_DONE, 4'h1, 4'h0, b + 10, b + 15);
    exp_rng("rt_done1", F_DONE, 4'h1, 4'h1, b + 16, b + 16);
    exp_rng("rt_miss", F_MISS, 4'h1, 4'h0, b + 16, b + 16);
    step_to(b + 9);  trig_in[0] = 1'b1;
    step_to(b + 10); trig_in[0] = 1'b0;
    step_to(b + 11); trig_in[0] = 1'b1;
    step_to(b + 12); trig_in[0] = 1'b0;
    step_to(b + 18);

    // Retrigger on the final pulse cycle, dur=2.
    b = cyc; set_dur(0, 8'd2);
    exp_rng("rtf_out_hi", F_OUT, 4'h1, 4'h1, b + 10, b + 13);
    exp_rng("rtf_out_lo", F_OUT, 4'h1, 4'h0, b + 14, b + 14);
    exp_rng("rtf_done0", F_DONE, 4'h1, 4'h0, b + 10, b + 13);
    exp_rng("rtf_done1", F_DONE, 4'h1, 4'h1, b + 14, b + 14);
    step_to(b + 9);  trig_in[0] = 1'b1;
    step_to(b + 10); trig_in[0] = 1'b0;
    step_to(b + 11); trig_in[0] = 1'b1;
    step_to(b + 12); trig_in[0] = 1'b0;
    step_to(b + 16);

    // Holdoff: dur=2, holdoff=3.
    b = cyc; set_dur(0, 8'd2); mode = 2'b10; holdoff = 8'd3;
    exp_rng("ho_out_hi", F_OUT, 4'h1, 4'h1, b + 10, b + 11);
    exp_rng("ho_out_lo", F_OUT, 4'h1, 4'h0, b + 12, b + 16);
    exp_rng("ho_done", F_DONE, 4'h1, 4'h1, b + 12, b + 12);
    exp_rng("ho_done0", F_DONE, 4'h1, 4'h0, b + 13, b + 15);
    exp_rng("ho_busy1", F_BUSY, 4'h1, 4'h1, b + 10, b + 14);
    exp_rng("ho_busy0", F_BUSY, 4'h1, 4'h0, b + 15, b + 16);
    exp_rng("ho_miss0", F_MISS, 4'h1, 4'h0, b + 12, b + 12);
    exp_rng("ho_miss1", F_MISS, 4'h1, 4'h1, b + 13, b + 18);
    exp_rng("ho_again", F_OUT, 4'h1, 4'h1, b + 17, b + 18);
    step_to(b + 9);  trig_in[0] = 1'b1;
    step_to(b + 10); trig_in[0] = 1'b0;
    step_to(b + 12); trig_in[0] = 1'b1;
    step_to(b + 13); trig_in[0] = 1'b0;
    step_to(b + 16); trig_in[0] = 1'b1;
    step_to(b + 17); trig_in[0] = 1'b0;
    step_to(b + 24);

    // dur=0 edge: no pulse, no miss.
    b = cyc; mode = 2'b00; holdoff = '0; set_dur(0, 8'd0);
    exp_rng("d0_clr", F_MISS, 4'hF, 4'h0, b + 2, b + 12);
    exp_rng("d0_out", F_OUT, 4'h1, 4'h0, b + 10, b + 12);
    exp_rng("d0_busy", F_BUSY, 4'h1, 4'h0, b + 10, b + 12);
    clr_miss = 1'b1;
    step_to(b + 1);  clr_miss = 1'b0;
    step_to(b + 9);  trig_in[0] = 1'b1;
    step_to(b + 12); trig_in[0] = 1'b0;
    step_to(b + 14);

    // Four channels with distinct widths; en[2] dropped mid-pulse.
    b = cyc;
    set_dur(0, 8'd1); set_dur(1, 8'd2); set_dur(2, 8'd3); set_dur(3, 8'd255);
    exp_rng("mc_out_10", F_OUT, 4'hF, 4'b1111, b + 10, b + 10);
    exp_rng("mc_out_11", F_OUT, 4'hF, 4'b1010, b + 11, b + 11);
    exp_rng("mc_out_12", F_OUT, 4'hF, 4'b1000, b + 12, b + 14);
    exp_rng("mc_done_11", F_DONE, 4'hF, 4'b0001, b + 11, b + 11);
    exp_rng("mc_done_12", F_DONE, 4'hF, 4'b0010, b + 12, b + 12);
    exp_rng("mc_done2_0", F_DONE, 4'h4, 4'h0, b + 10, b + 16);
    exp_rng("mc_busy2", F_BUSY, 4'h4, 4'h0, b + 11, b + 12);
    exp_rng("mc_miss", F_MISS, 4'hF, 4'h0, b + 12, b + 12);
    exp_rng("mc_ch3_hi", F_OUT, 4'h8, 4'h8, b + 264, b + 264);
    exp_rng("mc_ch3_lo", F_OUT, 4'h8, 4'h0, b + 265, b + 265);
    exp_rng("mc_ch3_done0", F_DONE, 4'h8, 4'h0, b + 264, b + 264);
    exp_rng("mc_ch3_done1", F_DONE, 4'h8, 4'h8, b + 265, b + 265);
    step_to(b + 9);  trig_in = 4'hF;
    step_to(b + 10); en[2] = 1'b0;
    step_to(b + 12); trig_in = 4'h0;
    step_to(b + 20); en[2] = 1'b1;
    step_to(b + 268);

    // Async reset mid-pulse.
    b = cyc; set_dur(0, 8'd10);
    exp_rng("ar_out_hi", F_OUT, 4'h1, 4'h1, b + 10, b + 12);
    step_to(b + 9);  trig_in[0] = 1'b1;
    step_to(b + 11); trig_in[0] = 1'b0;
    step_to(b + 13);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_now", out, 4'h0);
    chk("arst_done_now", done, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    b = cyc;
    exp_rng("ar_out_after", F_OUT, 4'h1, 4'h0, b + 1, b + 12);
    exp_rng("ar_done_after", F_DONE, 4'h1, 4'h0, b + 1, b + 12);
    step_to(b + 14);

    chk("sb_drained", 4'(sb.size()), 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
